// File: rtl/game_status_pkg.sv
// game_status_pkg: shared card-game constants, FSM state and two-digit BCD helpers
package game_status_pkg;

    localparam int NUM_CARDS = 36;
    localparam int NUM_PAIRS = 18;
    localparam logic [NUM_CARDS-1:0] ALL_HIDDEN = 36'hF_FFFF_FFFF;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] MISS_MAX  = 7'd99;

    typedef enum logic {PLAY = 1'b0, WON = 1'b1} state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam bcd2_t PAIRS_BCD = {4'(NUM_PAIRS / 10), 4'(NUM_PAIRS % 10)};
    localparam bcd2_t TIME_MAX  = 8'h99;

    function automatic bcd2_t bcd_inc(bcd2_t v);
        return (v.ones == 4'd9) ? {v.tens + 4'd1, 4'd0} : {v.tens, v.ones + 4'd1};
    endfunction

endpackage

// File: rtl/game_status_seg7_decode.sv
// seg7_decode: BCD digit to active-low {g,f,e,d,c,b,a}, codes 10-15 blank
module seg7_decode
    import game_status_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/game_status.sv
// game_status: PLAY/WON FSM with BCD time and pair counters, miss counter and 4-digit display scan
module game_status
    import game_status_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ms,
    input  logic                 mf,
    input  logic [NUM_CARDS-1:0] hidden_bus,
    output logic [6:0]           seg,
    output logic [3:0]           an,
    output logic                 game_won,
    output logic [6:0]           miss_count
);

    localparam int TW = $clog2(CLK_HZ + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);

    state_t        state, state_n;
    logic [TW-1:0] tick_cnt;
    logic [RW-1:0] ref_cnt;
    logic          sec_tick, ref_wrap, blink, blank;
    logic [1:0]    sel, sel_n;
    bcd2_t         tm, pair, pair_n;
    logic [3:0]    digit;
    logic [6:0]    seg_d;

    assign sec_tick = tick_cnt == TW'(CLK_HZ - 1);
    assign ref_wrap = ref_cnt == RW'(REFRESH_DIV - 1);
    assign sel_n    = ref_wrap ? sel + 2'd1 : sel;
    assign pair_n   = (state == PLAY && ms && pair != PAIRS_BCD) ? bcd_inc(pair) : pair;

    always_ff @(posedge clk) begin
        if (rst)
            state <= PLAY;
        else
            state <= state_n;
    end

    // Looking at pair_n lets the win land on the edge right after the final ms pulse.
    always_comb begin
        state_n = (state == PLAY && (hidden_bus == ALL_HIDDEN || pair_n == PAIRS_BCD)) ? WON : state;
    end

    always_comb begin
        game_won = state == WON;
        blank    = game_won && blink;
        digit    = (sel_n == 2'd0) ? pair.ones :
                   (sel_n == 2'd1) ? pair.tens :
                   (sel_n == 2'd2) ? tm.ones   : tm.tens;
    end

    seg7_decode u_dec (
        .bcd (digit),
        .seg (seg_d)
    );

    // an and seg both register from sel_n so the lit digit and its segments never skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            ref_cnt    <= '0;
            sel        <= 2'd0;
            tm         <= '0;
            pair       <= '0;
            miss_count <= '0;
            blink      <= 1'b0;
            an         <= 4'b1110;
            seg        <= SEG_ZERO;
        end else begin
            tick_cnt <= sec_tick ? '0 : tick_cnt + 1'b1;
            ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;
            sel      <= sel_n;
            pair     <= pair_n;
            if (state == PLAY && sec_tick && tm != TIME_MAX)
                tm <= bcd_inc(tm);
            if (state == PLAY && mf && miss_count != MISS_MAX)
                miss_count <= miss_count + 7'd1;
            if (state == WON && sec_tick)
                blink <= ~blink;
            an  <= ~(4'b0001 << sel_n);
            seg <= blank ? SEG_BLANK : seg_d;
        end
    end

endmodule

// File: tb/tb_game_status.sv
// tb_game_status: scoreboard bench for game_status at CLK_HZ=10, REFRESH_DIV=4
module tb_game_status;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ms = 1'b0;
    logic        mf = 1'b0;
    logic [35:0] hidden_bus = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        game_won;
    logic [6:0]  miss_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];

    game_status #(.CLK_HZ(10), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ms         (ms),
        .mf         (mf),
        .hidden_bus (hidden_bus),
        .seg        (seg),
        .an         (an),
        .game_won   (game_won),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ms = 1'b0;
        mf = 1'b0;
        hidden_bus = '0;
        steps(2);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Waits (bounded) for the given anode to be lit with a non-blank segment pattern.
    task automatic read_digit(input logic [3:0] pat, output logic [6:0] s, output bit ok);
        ok = 1'b0;
        s = 7'h7F;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (an === pat && seg !== 7'h7F) begin
                s = seg;
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (an !== 4'b1110) begin failures++; $display("FAIL reset_an: got %b expected 1110", an); end
        checks++;
        if (seg !== seg_of(0)) begin failures++; $display("FAIL reset_seg: got %b expected %b", seg, seg_of(0)); end
        checks++;
        if (game_won !== 1'b0) begin failures++; $display("FAIL reset_won: got %b expected 0", game_won); end
        checks++;
        if (miss_count !== 7'd0) begin failures++; $display("FAIL reset_miss: got %0d expected 0", miss_count); end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_time();
        int at[5];
        int e;
        at = '{251, 252, 255, 256, 260};
        do_reset();
        exp_q.push_back(int'({4'b1011, seg_of(5)}));
        exp_q.push_back(int'({4'b0111, seg_of(2)}));
        exp_q.push_back(int'({4'b0111, seg_of(2)}));
        exp_q.push_back(int'({4'b1110, seg_of(0)}));
        exp_q.push_back(int'({4'b1101, seg_of(0)}));
        for (int i = 0; i < 5; i++) begin
            while (cyc < at[i]) step();
            e = exp_q.pop_front();
            checks++;
            if ({an, seg} !== 11'(e))
                begin failures++; $display("FAIL time_scan cyc %0d: an/seg=%b expected %b", cyc, {an, seg}, 11'(e)); end
        end
        checks++;
        if (game_won !== 1'b0) begin failures++; $display("FAIL time_won: got %b expected 0", game_won); end
    endtask

    task automatic test_pairs();
        int p = 0;
        int w = 0;
        int e;
        logic [6:0] s;
        bit ok;
        do_reset();
        for (int i = 1; i <= 18; i++) begin
            ms = 1'b1;
            step();
            ms = 1'b0;
            p++;
            if (i == 18) begin
                w = cyc;
                checks++;
                if (game_won !== 1'b1) begin failures++; $display("FAIL pairs_won_edge: got %b expected 1", game_won); end
            end
            steps(2);
            if (i == 9 || i == 10 || i == 17) begin
                exp_q.push_back(p);
                read_digit(4'b1110, s, ok);
                e = exp_q[0];
                checks++;
                if (!ok || s !== seg_of(e % 10))
                    begin failures++; $display("FAIL pair_ones after %0d ms: seg=%b expected %b", i, s, seg_of(e % 10)); end
                read_digit(4'b1101, s, ok);
                e = exp_q.pop_front();
                checks++;
                if (!ok || s !== seg_of(e / 10))
                    begin failures++; $display("FAIL pair_tens after %0d ms: seg=%b expected %b", i, s, seg_of(e / 10)); end
            end
            if (i == 17) begin
                checks++;
                if (game_won !== 1'b0) begin failures++; $display("FAIL pairs_early_won: got %b expected 0", game_won); end
            end
        end
        ms = 1'b1;
        step();
        ms = 1'b0;
        steps(30);
        exp_q.push_back(w / 10);
        read_digit(4'b1011, s, ok);
        e = exp_q[0];
        checks++;
        if (!ok || s !== seg_of(e % 10)) begin failures++; $display("FAIL frozen_time_ones: seg=%b expected %b", s, seg_of(e % 10)); end
        read_digit(4'b0111, s, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || s !== seg_of(e / 10)) begin failures++; $display("FAIL frozen_time_tens: seg=%b expected %b", s, seg_of(e / 10)); end
        exp_q.push_back(18);
        read_digit(4'b1110, s, ok);
        e = exp_q[0];
        checks++;
        if (!ok || s !== seg_of(e % 10)) begin failures++; $display("FAIL won_pair_ones: seg=%b expected %b", s, seg_of(e % 10)); end
        read_digit(4'b1101, s, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || s !== seg_of(e / 10)) begin failures++; $display("FAIL won_pair_tens: seg=%b expected %b", s, seg_of(e / 10)); end
    endtask

    task automatic test_coincident();
        int e;
        logic [6:0] s;
        bit ok;
        do_reset();
        while (cyc < 9) step();
        ms = 1'b1;
        mf = 1'b1;
        step();
        ms = 1'b0;
        mf = 1'b0;
        checks++;
        if (miss_count !== 7'd1) begin failures++; $display("FAIL coinc_miss: got %0d expected 1", miss_count); end
        exp_q.push_back(1);
        read_digit(4'b1110, s, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || s !== seg_of(e)) begin failures++; $display("FAIL coinc_pair: seg=%b expected %b", s, seg_of(e)); end
        read_digit(4'b1011, s, ok);
        exp_q.push_back(((cyc - 1) / 10) % 10);
        e = exp_q.pop_front();
        checks++;
        if (!ok || s !== seg_of(e)) begin failures++; $display("FAIL coinc_time: seg=%b expected %b", s, seg_of(e)); end
    endtask

    task automatic test_miss_sat();
        int e;
        do_reset();
        for (int i = 1; i <= 120; i++) begin
            mf = 1'b1;
            exp_q.push_back(i < 99 ? i : 99);
            step();
            mf = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (miss_count !== 7'(e)) begin failures++; $display("FAIL miss_count pulse %0d: got %0d expected %0d", i, miss_count, e); end
            step();
        end
        steps(5);
        checks++;
        if (miss_count !== 7'd99) begin failures++; $display("FAIL miss_hold: got %0d expected 99", miss_count); end
    endtask

    task automatic test_hidden_won();
        int e;
        int blanks = 0;
        logic [6:0] s;
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ms = 1'b1;
            mf = (i < 3);
            step();
            ms = 1'b0;
            mf = 1'b0;
            step();
        end
        checks++;
        if (game_won !== 1'b0) begin failures++; $display("FAIL hidden_pre_won: got %b expected 0", game_won); end
        hidden_bus = '1;
        step();
        hidden_bus = '0;
        checks++;
        if (game_won !== 1'b1) begin failures++; $display("FAIL hidden_won_edge: got %b expected 1", game_won); end
        steps(5);
        checks++;
        if (game_won !== 1'b1) begin failures++; $display("FAIL won_sticky: got %b expected 1", game_won); end
        ms = 1'b1;
        mf = 1'b1;
        step();
        ms = 1'b0;
        mf = 1'b0;
        step();
        checks++;
        if (miss_count !== 7'd3) begin failures++; $display("FAIL won_mf_ignored: got %0d expected 3", miss_count); end
        exp_q.push_back(5);
        read_digit(4'b1110, s, ok);
        e = exp_q[0];
        checks++;
        if (!ok || s !== seg_of(e % 10)) begin failures++; $display("FAIL won_ms_ones: seg=%b expected %b", s, seg_of(e % 10)); end
        read_digit(4'b1101, s, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || s !== seg_of(e / 10)) begin failures++; $display("FAIL won_ms_tens: seg=%b expected %b", s, seg_of(e / 10)); end
        for (int i = 0; i < 40; i++) begin
            step();
            if (seg === 7'h7F) blanks++;
        end
        checks++;
        if (blanks != 20) begin failures++; $display("FAIL blink_blanks: got %0d of 40 expected 20", blanks); end
    endtask

    task automatic test_rst_in_won();
        int e;
        logic [6:0] s;
        bit ok;
        checks++;
        if (game_won !== 1'b1) begin failures++; $display("FAIL rst_pre_won: got %b expected 1", game_won); end
        rst = 1'b1;
        ms = 1'b1;
        mf = 1'b1;
        step();
        ms = 1'b0;
        mf = 1'b0;
        checks++;
        if (game_won !== 1'b0) begin failures++; $display("FAIL rst_won: got %b expected 0", game_won); end
        checks++;
        if (an !== 4'b1110) begin failures++; $display("FAIL rst_an: got %b expected 1110", an); end
        checks++;
        if (seg !== seg_of(0)) begin failures++; $display("FAIL rst_seg: got %b expected %b", seg, seg_of(0)); end
        checks++;
        if (miss_count !== 7'd0) begin failures++; $display("FAIL rst_miss: got %0d expected 0", miss_count); end
        rst = 1'b0;
        cyc = 0;
        exp_q.push_back(0);
        read_digit(4'b1101, s, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || s !== seg_of(e)) begin failures++; $display("FAIL rst_pair_tens: seg=%b expected %b", s, seg_of(e)); end
    endtask

    initial begin
        test_reset();
        test_time();
        test_pairs();
        test_coincident();
        test_miss_sat();
        test_hidden_won();
        test_rst_in_won();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_status.md
GAME_STATUS -- requirements
Module: game_status

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock cycles per one-second tick.
REQ-002 Parameter REFRESH_DIV, default 100000, cycles each seven-segment digit stays lit.
REQ-003 clk  input  1  system clock; the single clock domain, all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ms  input  1  match-success pulse from the matcher, one cycle wide.
REQ-006 mf  input  1  match-fail pulse from the matcher, one cycle wide.
REQ-007 hidden_bus  input  36  per-card removed flags from card_array; bit=1 means the card is removed.
REQ-008 seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  4  digit anodes, active-low, exactly one low at a time.
REQ-010 game_won  output  1  high while in state WON.
REQ-011 miss_count  output  7  binary count of mf pulses, saturating at 99.

Function
REQ-012 The FSM SHALL have exactly two states: PLAY (reset state) and WON.
REQ-013 PLAY->WON SHALL occur on the edge after hidden_bus==36'hF_FFFF_FFFF or pair_count reaching 18, whichever is first.
REQ-014 WON SHALL be left only by rst.
REQ-015 A tick counter SHALL count 0..CLK_HZ-1 and wrap; the wrap cycle is the one-cycle sec_tick.
REQ-016 In PLAY each sec_tick SHALL increment the 2-digit BCD time register (00..99).
REQ-017 The time register SHALL saturate at 99.
REQ-018 In WON the time register SHALL freeze.
REQ-019 In PLAY each ms pulse SHALL increment the 2-digit BCD pair_count (00..18), ones digit wrapping 9->0 with tens carry.
REQ-020 ms SHALL be ignored in WON.
REQ-021 ms SHALL be ignored when pair_count==18.
REQ-022 Each mf pulse SHALL increment miss_count, saturating at 99.
REQ-023 mf SHALL be ignored in WON.
REQ-024 ms and mf in the same cycle SHALL both be counted.
REQ-025 ms or mf coincident with sec_tick SHALL update independently, with no lost count.
REQ-026 A refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, digit select SHALL advance 0->1->2->3->0.
REQ-027 Digit mapping: select 0 -> an=4'b1110 shows pair ones; 1 -> 4'b1101 pair tens; 2 -> 4'b1011 time ones; 3 -> 4'b0111 time tens.
REQ-028 seg SHALL be the registered decode of the selected BCD digit, updated on the same edge as an (no digit/segment skew).
REQ-029 In WON, seg SHALL blank (7'h7F) on alternate seconds, driven by sec_tick toggling a blink flag.
REQ-030 All outputs SHALL be registered.
REQ-031 Output latency from an ms pulse to the updated pair digit in the seg path SHALL be at most 1 cycle plus the digit-select wait.

Reset
REQ-032 rst SHALL synchronously set: state=PLAY, time=00, pair_count=00, miss_count=0, tick and refresh counters=0, digit select=0, blink flag=0.
REQ-033 On the edge after rst, outputs SHALL be an=4'b1110, seg=7'b1000000 (digit 0), game_won=0.
REQ-034 rst asserted mid-count or in WON SHALL take precedence over every same-cycle event, including ms, mf and sec_tick.

Structure
REQ-035 Shared constants NUM_CARDS=36, NUM_PAIRS=18 and ALL_HIDDEN=36'hF_FFFF_FFFF SHALL live in the project-wide constants include, also used by card_array and matcher.
REQ-036 BCD-to-seven-segment decoding SHALL be a combinational sub-module, seg7_decode (4-bit in, 7-bit active-low out; codes 10-15 blank).
REQ-037 game_status SHALL be instantiated in top, fed by matcher ms/mf and card_array hidden_bus.
REQ-038 game_status SHALL drive seg/an pins.

Verification (CLK_HZ=10, REFRESH_DIV=4)
REQ-039 rst, then 25 ticks (250 cycles) idle -> time=25; an cycles 1110,1101,1011,0111 every 4 cycles; digit 2 seg=7'b0010010 ("5").
REQ-040 18 ms pulses spaced 3 cycles -> pair_count 01..18 with carry at 09->10; game_won=1 on the edge after the 18th pulse; time frozen.
REQ-041 ms and mf in the same cycle, coincident with sec_tick -> pair +1, miss +1, time +1.
REQ-042 120 mf pulses -> miss_count=99 and held.
REQ-043 hidden_bus=all ones with pair_count=5 -> game_won next edge; a later ms leaves pair at 05; seg blanks on alternate seconds.
REQ-044 rst during WON with ms high -> next edge pair=00, game_won=0, an=4'b1110.
